interval_arbiter: RTL and testbench

Round-robin scheduler that shares one 4-bit loadable up/down counter among up to N_REQ requesters, each asking for a down-count interval of its own length. It sits beside the counter and drives the counter's data, load, mode and enable inputs. It watches the counter value to detect expiry, then pulses a per-requester done strobe. Requesters never touch the counter directly.

---
 rtl/interval_arbiter_if.sv | 28 ++
 rtl/interval_arbiter.sv | 139 +++++++++++++
 tb/tb_interval_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/interval_arbiter_if.sv
// Requester/counter bundle for interval_arbiter: request levels and lengths in,
// grant/done strobes out, plus the shared 4-bit counter control and readback.
interface interval_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [4*N_REQ-1:0] len;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic               busy;
  logic [3:0]         cnt_d;
  logic               cnt_ld;
  logic               cnt_m;
  logic               cnt_ce;
  logic [3:0]         cnt_q;

  // requesters plus the counter itself
  modport master (
    output req, len, cnt_q,
    input  gnt, done, busy, cnt_d, cnt_ld, cnt_m, cnt_ce
  );

  // the arbiter
  modport slave (
    input  req, len, cnt_q,
    output gnt, done, busy, cnt_d, cnt_ld, cnt_m, cnt_ce
  );
endinterface

// File: rtl/interval_arbiter.sv
// Round-robin scheduler sharing one loadable 4-bit down-counter among N_REQ
// requesters; each grant loads its interval, counts it out and pulses done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no grant; pick next requester after last, wrapping
// LOAD    | load LEN[idx] into the counter
// RUN     | counter decrements until zero; withdrawal aborts to IDLE
// DONE    | one-cycle done pulse to idx, then back to IDLE
module interval_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  interval_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [IDX_W-1:0] last_q,  last_d;

  logic [IDX_W-1:0] pick;
  logic             pick_vld;
  logic [IDX_W-1:0] cand;
  logic [3:0]       len_sel;
  logic             cnt_zero;

  logic [N_REQ-1:0] gnt_c;
  logic [N_REQ-1:0] done_c;
  logic [3:0]       cnt_d_c;
  logic             cnt_ld_c;
  logic             cnt_m_c;
  logic             cnt_ce_c;

  // N_REQ need not be a power of two, so the wrap is an explicit compare
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  assign len_sel  = bus.len[{idx_q, 2'b00} +: 4];
  assign cnt_zero = (bus.cnt_q == 4'd0);

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = wrap_add(last_q, i);
      if (!pick_vld && bus.req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    gnt_c    = '0;
    done_c   = '0;
    cnt_d_c  = 4'd0;
    cnt_ld_c = 1'b0;
    cnt_m_c  = 1'b0;
    cnt_ce_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          idx_d   = pick;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        gnt_c[idx_q] = 1'b1;
        cnt_d_c      = len_sel;
        cnt_ld_c     = 1'b1;
        cnt_ce_c     = 1'b1;
        cnt_m_c      = 1'b1;
        state_d      = ST_RUN;
      end

      ST_RUN: begin
        gnt_c[idx_q] = 1'b1;
        cnt_m_c      = 1'b1;
        // holding CE low at zero keeps the counter from wrapping to 15
        cnt_ce_c     = !cnt_zero;
        if (cnt_zero) begin
          state_d = ST_DONE;
        end else if (!bus.req[idx_q]) begin
          state_d = ST_IDLE;
          last_d  = idx_q;
        end
      end

      ST_DONE: begin
        done_c[idx_q] = 1'b1;
        last_d        = idx_q;
        state_d       = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.gnt    = gnt_c;
  assign bus.done   = done_c;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.cnt_d  = cnt_d_c;
  assign bus.cnt_ld = cnt_ld_c;
  assign bus.cnt_m  = cnt_m_c;
  assign bus.cnt_ce = cnt_ce_c;

endmodule

// File: tb/tb_interval_arbiter.sv
// Directed bench for interval_arbiter with a behavioural 4-bit up/down counter
// closing the loop on cnt_q.
module tb_interval_arbiter;

  logic clk;
  logic rst_n;

  interval_arbiter_if #(.N_REQ(4)) bus ();

  interval_arbiter #(.N_REQ(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared counter: load beats count, M=1 counts down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cnt_q <= 4'd0;
    end else if (bus.cnt_ce) begin
      if (bus.cnt_ld)     bus.cnt_q <= bus.cnt_d;
      else if (bus.cnt_m) bus.cnt_q <= bus.cnt_q - 4'd1;
      else                bus.cnt_q <= bus.cnt_q + 4'd1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".gnt"},    32'(bus.gnt),    32'd0);
    check({tag, ".done"},   32'(bus.done),   32'd0);
    check({tag, ".busy"},   32'(bus.busy),   32'd0);
    check({tag, ".cnt_d"},  32'(bus.cnt_d),  32'd0);
    check({tag, ".cnt_ld"}, 32'(bus.cnt_ld), 32'd0);
    check({tag, ".cnt_m"},  32'(bus.cnt_m),  32'd0);
    check({tag, ".cnt_ce"}, 32'(bus.cnt_ce), 32'd0);
  endtask

  // Called at a negedge while IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_txn(input logic [3:0] req, input logic [15:0] len, input int exp_idx, input string tag);
    logic [3:0] oh;
    int L;
    int exp_q;
    oh = 4'b0001 << exp_idx;
    L  = int'(len[exp_idx*4 +: 4]);
    bus.req = req;
    bus.len = len;
    @(posedge clk);
    for (int k = 1; k <= L + 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({tag, ".load.gnt"},   32'(bus.gnt),    32'(oh));
        check({tag, ".load.cnt_d"}, 32'(bus.cnt_d),  32'(L));
        check({tag, ".load.ld"},    32'(bus.cnt_ld), 32'd1);
        check({tag, ".load.ce"},    32'(bus.cnt_ce), 32'd1);
        check({tag, ".load.m"},     32'(bus.cnt_m),  32'd1);
        check({tag, ".load.busy"},  32'(bus.busy),   32'd1);
        check({tag, ".load.done"},  32'(bus.done),   32'd0);
      end else if (k <= L + 2) begin
        exp_q = L - (k - 2);
        check({tag, ".run.gnt"},   32'(bus.gnt),    32'(oh));
        check({tag, ".run.q"},     32'(bus.cnt_q),  32'(exp_q));
        check({tag, ".run.ce"},    32'(bus.cnt_ce), (exp_q != 0) ? 32'd1 : 32'd0);
        check({tag, ".run.ld"},    32'(bus.cnt_ld), 32'd0);
        check({tag, ".run.m"},     32'(bus.cnt_m),  32'd1);
        check({tag, ".run.done"},  32'(bus.done),   32'd0);
        check({tag, ".run.busy"},  32'(bus.busy),   32'd1);
      end else if (k == L + 3) begin
        check({tag, ".done.done"}, 32'(bus.done),   32'(oh));
        check({tag, ".done.gnt"},  32'(bus.gnt),    32'd0);
        check({tag, ".done.ce"},   32'(bus.cnt_ce), 32'd0);
        check({tag, ".done.ld"},   32'(bus.cnt_ld), 32'd0);
        check({tag, ".done.busy"}, 32'(bus.busy),   32'd1);
        check({tag, ".done.q"},    32'(bus.cnt_q),  32'd0);
        bus.req = 4'b0000;
      end else begin
        check_quiet({tag, ".idle"});
        check({tag, ".idle.q"}, 32'(bus.cnt_q), 32'd0);
      end
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] len;
    int          exp_idx;
    string       name;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[5];
    int cyc;
    int last_done;
    bit found;

    // Round-robin state going into the table is last=0 (left by the rr sequence).
    vecs[0] = '{4'b0001, 16'h0003, 0, "v0_len3"};
    vecs[1] = '{4'b0100, 16'h0000, 2, "v1_len0"};
    vecs[2] = '{4'b0010, 16'h00F0, 1, "v2_len15"};
    vecs[3] = '{4'b1001, 16'h5002, 3, "v3_rr_skip"};
    vecs[4] = '{4'b1001, 16'h5002, 0, "v4_rr_wrap"};
    vecs[5] = '{4'b0110, 16'h0740, 1, "v5_pair"};
    vecs[6] = '{4'b1100, 16'h9600, 2, "v6_pair_hi"};
    order   = '{0, 1, 2, 3, 0};

    rst_n   = 1'b0;
    bus.req = 4'b0000;
    bus.len = 16'h0000;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // All four requesting, LEN=1 each: period L+4 = 5 cycles between DONEs.
    bus.req   = 4'b1111;
    bus.len   = 16'h1111;
    cyc       = 0;
    last_done = 0;
    for (int g = 0; g < 5; g++) begin
      found = 1'b0;
      for (int w = 0; w < 20 && !found; w++) begin
        @(negedge clk);
        cyc++;
        if (bus.done != 4'b0000) begin
          found = 1'b1;
          check("rr.done", 32'(bus.done), 32'(4'b0001 << order[g]));
          if (g == 0) check("rr.first", 32'(cyc), 32'd4);
          else        check("rr.spacing", 32'(cyc - last_done), 32'd5);
          last_done = cyc;
          if (g == 4) bus.req = 4'b0000;
        end
      end
      if (!found) check("rr.timeout", 32'd0, 32'd1);
    end
    @(negedge clk);
    check("rr.idle.busy", 32'(bus.busy), 32'd0);

    for (int v = 0; v < 7; v++)
      run_txn(vecs[v].req, vecs[v].len, vecs[v].exp_idx, vecs[v].name);

    // Withdrawal: last=2, so req 0110 grants 1 first; drop it at Q=9.
    bus.req = 4'b0110;
    bus.len = 16'h03F0;
    @(posedge clk);
    @(negedge clk);
    check("abort.load.gnt", 32'(bus.gnt), 32'd2);
    found = 1'b0;
    for (int w = 0; w < 30 && !found; w++) begin
      @(negedge clk);
      if (bus.cnt_q == 4'd9) found = 1'b1;
    end
    check("abort.reach9", 32'(found), 32'd1);
    check("abort.run.gnt", 32'(bus.gnt), 32'd2);
    bus.req = 4'b0100;
    @(negedge clk);
    check_quiet("abort.idle");
    @(negedge clk);
    check("abort.next.gnt", 32'(bus.gnt), 32'd4);
    check("abort.next.cnt_d", 32'(bus.cnt_d), 32'd3);
    check("abort.next.ld", 32'(bus.cnt_ld), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort.next.run.done", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    check("abort.next.done", 32'(bus.done), 32'd4);
    bus.req = 4'b0000;
    @(negedge clk);
    check("abort.end.busy", 32'(bus.busy), 32'd0);

    // Async reset mid-RUN at Q=6, then 1010 must go to requester 1 first.
    bus.req = 4'b0001;
    bus.len = 16'h000A;
    @(posedge clk);
    found = 1'b0;
    for (int w = 0; w < 30 && !found; w++) begin
      @(negedge clk);
      if (bus.cnt_q == 4'd6) found = 1'b1;
    end
    check("arst.reach6", 32'(found), 32'd1);
    check("arst.run.gnt", 32'(bus.gnt), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_quiet("arst");
    bus.req = 4'b1010;
    bus.len = 16'h4020;
    @(negedge clk);
    check("arst.held.busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    run_txn(4'b1010, 16'h4020, 1, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
